// File: rtl/gshare_branch_pred.sv
// Multi-port gshare predictor: one saturating-counter table indexed by pc ^ ghr, swept to weakly-not-taken after reset.
// Optional GSHARE_BYPASS_EN: same-cycle lookups see the post-feedback ghr and counter.
module gshare_lookup_lane #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 5,
  parameter int GHR_W = 3,
  parameter int CTR_W = 2,
  parameter int DEPTH = 2**IDX_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         lookup_en,
  input  logic                         req_valid,
  input  logic [PC_W-1:0]              req_pc,
  input  logic [GHR_W-1:0]             ghr,
  input  logic [DEPTH-1:0][CTR_W-1:0]  tbl,
  output logic                         rsp_valid,
  output logic                         rsp_taken,
  output logic                         rsp_exec_alt,
  output logic [GHR_W-1:0]             rsp_ghr
);
  localparam logic [CTR_W-1:0] WNT = CTR_W'(2**(CTR_W-1)-1);
  localparam logic [CTR_W-1:0] WT  = CTR_W'(2**(CTR_W-1));

  logic [IDX_W-1:0] idx;
  logic [CTR_W-1:0] ctr;
  logic             rsp_valid_d, rsp_taken_d, rsp_exec_alt_d;
  logic [GHR_W-1:0] rsp_ghr_d;
  logic             pc_unused;

  assign pc_unused = ^{req_pc[PC_W-1:IDX_W+2], req_pc[1:0]};

  always_comb begin
    idx            = req_pc[IDX_W+1:2] ^ IDX_W'(ghr);
    ctr            = tbl[idx];
    rsp_valid_d    = lookup_en & req_valid;
    rsp_taken_d    = rsp_valid_d & ctr[CTR_W-1];
    rsp_exec_alt_d = rsp_valid_d & ((ctr == WNT) || (ctr == WT));
    rsp_ghr_d      = rsp_valid_d ? ghr : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_taken    <= 1'b0;
      rsp_exec_alt <= 1'b0;
      rsp_ghr      <= '0;
    end else begin
      rsp_valid    <= rsp_valid_d;
      rsp_taken    <= rsp_taken_d;
      rsp_exec_alt <= rsp_exec_alt_d;
      rsp_ghr      <= rsp_ghr_d;
    end
  end
endmodule

module gshare_branch_pred #(
  parameter int REQ_PORTS = 3,
  parameter int PC_W      = 32,
  parameter int IDX_W     = 5,
  parameter int GHR_W     = 3,
  parameter int CTR_W     = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  output logic                             init_done,
  input  logic [REQ_PORTS-1:0]             req_valid,
  input  logic [REQ_PORTS-1:0][PC_W-1:0]   req_pc,
  output logic [REQ_PORTS-1:0]             rsp_valid,
  output logic [REQ_PORTS-1:0]             rsp_taken,
  output logic [REQ_PORTS-1:0]             rsp_exec_alt,
  output logic [REQ_PORTS-1:0][GHR_W-1:0]  rsp_ghr,
  input  logic                             fb_valid,
  input  logic [PC_W-1:0]                  fb_pc,
  input  logic                             fb_taken,
  input  logic [GHR_W-1:0]                 fb_ghr
);
  localparam int               DEPTH   = 2**IDX_W;
  localparam logic [CTR_W-1:0] WNT     = CTR_W'(2**(CTR_W-1)-1);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e                        state_q, state_d;
  logic [IDX_W-1:0]              sweep_idx_q, sweep_idx_d;
  logic [GHR_W-1:0]              ghr_q, ghr_d, ghr_view;
  logic [DEPTH-1:0][CTR_W-1:0]   tbl_q, tbl_d, tbl_view;
  logic [IDX_W-1:0]              fidx;
  logic [CTR_W-1:0]              fctr;
  logic [GHR_W:0]                ghr_hist;
  logic                          upd, lookup_en;
  logic                          fb_pc_unused;

  assign fb_pc_unused = ^{fb_pc[PC_W-1:IDX_W+2], fb_pc[1:0]};
  assign lookup_en    = (state_q == S_RUN) & en;
  assign upd          = lookup_en & fb_valid;
  assign init_done    = (state_q == S_RUN);

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    tbl_d       = tbl_q;
    ghr_d       = ghr_q;
    fidx        = fb_pc[IDX_W+1:2] ^ IDX_W'(fb_ghr);
    fctr        = tbl_q[fidx];
    ghr_hist    = {ghr_q, fb_taken};
    case (state_q)
      S_INIT: begin
        tbl_d[sweep_idx_q] = WNT;
        sweep_idx_d        = sweep_idx_q + 1'b1;
        if (sweep_idx_q == IDX_W'(DEPTH-1)) state_d = S_RUN;
      end
      S_RUN: begin
        if (upd) begin
          if (fb_taken) tbl_d[fidx] = (fctr == CTR_MAX) ? fctr : fctr + 1'b1;
          else          tbl_d[fidx] = (fctr == '0)      ? fctr : fctr - 1'b1;
          ghr_d = ghr_hist[GHR_W-1:0];
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Outside INIT, *_d equals *_q unless feedback is applied this cycle, so the _d view is exactly the bypass view.
`ifdef GSHARE_BYPASS_EN
  assign tbl_view = tbl_d;
  assign ghr_view = ghr_d;
`else
  assign tbl_view = tbl_q;
  assign ghr_view = ghr_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      sweep_idx_q <= '0;
      ghr_q       <= '0;
      tbl_q       <= {DEPTH{WNT}};
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      ghr_q       <= ghr_d;
      tbl_q       <= tbl_d;
    end
  end

  for (genvar p = 0; p < REQ_PORTS; p++) begin : g_lane
    gshare_lookup_lane #(
      .PC_W(PC_W), .IDX_W(IDX_W), .GHR_W(GHR_W), .CTR_W(CTR_W), .DEPTH(DEPTH)
    ) u_lane (
      .clk          (clk),
      .rst          (rst),
      .lookup_en    (lookup_en),
      .req_valid    (req_valid[p]),
      .req_pc       (req_pc[p]),
      .ghr          (ghr_view),
      .tbl          (tbl_view),
      .rsp_valid    (rsp_valid[p]),
      .rsp_taken    (rsp_taken[p]),
      .rsp_exec_alt (rsp_exec_alt[p]),
      .rsp_ghr      (rsp_ghr[p])
    );
  end
endmodule
